// File: rtl/cpu_pkg.sv
// cpu_pkg: constants shared across the pipelined MIPS core.
//   NOP_INSTR : instruction word decode sees when nothing is queued.
//   RESET_PC  : PC the fetch stage starts from. It is also the PC shown
//               to decode while the fetch queue is empty.
package cpu_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] RESET_PC  = 32'h0000_3000;

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: DEPTH-entry instruction/PC buffer between fetch and decode.
// It absorbs decode stalls, presents the oldest entry to decode, and drops
// everything on a redirect (flush).
//
// Optional feature: define FETCH_QUEUE_BYPASS_EN to let an instruction pass
// straight from fetch to decode in the same cycle while the queue is empty.
//
// Parameters:
//   DEPTH   number of entries (power of two, >= 2)
//   DATA_W  instruction / PC width
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   in_valid   fetch presents an instruction
//   in_instr   fetched instruction word
//   in_pc      PC of in_instr
//   in_ready   queue can accept a push (fetch PC enable)
//   out_valid  head entry valid
//   out_ready  decode consumes the head (inverted decode stall)
//   out_instr  head instruction, NOP when empty
//   out_pc     head PC, RESET_PC when empty
//   flush      redirect: discard all entries
//   count      current occupancy
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_instr,
  input  logic [DATA_W-1:0]        in_pc,
  output logic                     in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_instr,
  output logic [DATA_W-1:0]        out_pc,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [DATA_W-1:0] instr_mem [DEPTH];
  logic [DATA_W-1:0] pc_mem    [DEPTH];

  logic stored_valid;
  logic push;
  logic pop;
  logic do_write;
  logic do_read;

  assign stored_valid = (count != '0);
  assign in_ready     = (count != CNT_W'(DEPTH));

`ifdef FETCH_QUEUE_BYPASS_EN
  // While empty, fetch's instruction is shown to decode in the same cycle.
  // If decode takes it, it never touches storage; otherwise it is written.
  logic bypass;
  assign bypass    = !stored_valid && in_valid && !flush;
  assign out_valid = stored_valid || bypass;
  assign out_instr = stored_valid ? instr_mem[rd_ptr] :
                     bypass       ? in_instr : DATA_W'(NOP_INSTR);
  assign out_pc    = stored_valid ? pc_mem[rd_ptr] :
                     bypass       ? in_pc    : DATA_W'(RESET_PC);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign do_write  = push && !(bypass && out_ready);
  assign do_read   = pop && !bypass;
`else
  // Outputs come only from registered state; empty shows NOP at RESET_PC.
  assign out_valid = stored_valid;
  assign out_instr = stored_valid ? instr_mem[rd_ptr] : DATA_W'(NOP_INSTR);
  assign out_pc    = stored_valid ? pc_mem[rd_ptr]    : DATA_W'(RESET_PC);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign do_write  = push;
  assign do_read   = pop;
`endif

  // Pointers and occupancy. Flush wins over any push/pop in the same cycle;
  // pointers wrap by natural overflow since DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_read)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_write, do_read})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage has no reset; empty outputs are masked above instead.
  always_ff @(posedge clk) begin
    if (do_write && !flush) begin
      instr_mem[wr_ptr] <= in_instr;
      pc_mem[wr_ptr]    <= in_pc;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: self-checking bench for fetch_queue.
// Directed sequences with literal expectations, then random traffic checked
// every cycle against a queue-based model of the buffer.
module tb_fetch_queue;
  import cpu_pkg::*;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic [DATA_W-1:0] in_instr;
  logic [DATA_W-1:0] in_pc;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_instr;
  logic [DATA_W-1:0] out_pc;
  logic              flush;
  logic [2:0]        count;

  int checks = 0;
  int errors = 0;

  // Model: queued entries, oldest at index 0.
  logic [DATA_W-1:0] model_instr [$];
  logic [DATA_W-1:0] model_pc    [$];

`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  fetch_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_pc    (out_pc),
    .flush     (flush),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  // Compare all DUT outputs with what the model says they must be now.
  task automatic compareModel();
    int          n;
    bit          byp;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    n       = model_pc.size();
    byp     = BYPASS && (n == 0) && in_valid && !flush;
    e_valid = (n != 0) || byp;
    e_instr = (n != 0) ? model_instr[0] : (byp ? in_instr : NOP_INSTR);
    e_pc    = (n != 0) ? model_pc[0]    : (byp ? in_pc    : RESET_PC);
    checkOutput("model count",     32'(count),     32'(n));
    checkOutput("model in_ready",  32'(in_ready),  32'(n != DEPTH));
    checkOutput("model out_valid", 32'(out_valid), 32'(e_valid));
    checkOutput("model out_instr", out_instr,      e_instr);
    checkOutput("model out_pc",    out_pc,         e_pc);
  endtask

  // Drive one cycle of inputs (called just after a rising edge), check at
  // the falling edge, then advance the model across the next rising edge.
  task automatic applyStimulus(input logic iv, input logic [31:0] instr,
                               input logic [31:0] pc, input logic ordy,
                               input logic fl);
    int n;
    bit byp, do_pop, do_push;
    in_valid  = iv;
    in_instr  = instr;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    @(negedge clk);
    compareModel();
    n       = model_pc.size();
    byp     = BYPASS && (n == 0) && iv && !fl;
    do_pop  = ((n != 0) || byp) && ordy;
    do_push = iv && (n != DEPTH);
    @(posedge clk);
    if (fl) begin
      model_instr.delete();
      model_pc.delete();
    end else if (!(byp && ordy)) begin
      if (do_pop) begin
        void'(model_instr.pop_front());
        void'(model_pc.pop_front());
      end
      if (do_push) begin
        model_instr.push_back(instr);
        model_pc.push_back(pc);
      end
    end
    #1;
  endtask

  initial begin
    logic [31:0] pc_next;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_instr  = '0;
    in_pc     = '0;
    out_ready = 1'b0;
    flush     = 1'b0;
    #12;
    reset = 1'b0;

    checkOutput("reset count",     32'(count),     32'd0);
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset in_ready",  32'(in_ready),  32'd1);
    checkOutput("reset out_instr", out_instr,      32'h0000_0000);
    checkOutput("reset out_pc",    out_pc,         32'h0000_3000);
    @(posedge clk);
    #1;

    // Fill with decode stalled, then try a fifth push.
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, 32'h2400_0000 + 32'(i), 32'h3000 + 32'(4 * i), 1'b0, 1'b0);
    checkOutput("full count",    32'(count),    32'd4);
    checkOutput("full in_ready", 32'(in_ready), 32'd0);
    applyStimulus(1'b1, 32'h2400_00ff, 32'h3010, 1'b0, 1'b0);
    checkOutput("fifth push ignored count", 32'(count), 32'd4);

    // Drain in order.
    for (int i = 0; i < 4; i++) begin
      checkOutput("drain head pc", out_pc, 32'h3000 + 32'(4 * i));
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    end
    checkOutput("drained out_valid", 32'(out_valid), 32'd0);
    checkOutput("drained out_instr", out_instr,      32'h0000_0000);
    checkOutput("drained out_pc",    out_pc,         32'h0000_3000);

    // Continuous push+pop: occupancy holds steady and order is kept.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 32'h2000_0000 + 32'(i), 32'h3000 + 32'(4 * i), 1'b1, 1'b0);
      checkOutput("stream count", 32'(count), BYPASS ? 32'd0 : 32'd1);
      checkOutput("stream head pc", out_pc, 32'h3000 + 32'(4 * i));
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checkOutput("stream drained count", 32'(count), 32'd0);

    // Flush at count 3 with simultaneous push and pop.
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 32'h3c00_0000 + 32'(i), 32'h3100 + 32'(4 * i), 1'b0, 1'b0);
    checkOutput("pre-flush count", 32'(count), 32'd3);
    applyStimulus(1'b1, 32'h3c00_00aa, 32'h3200, 1'b1, 1'b1);
    checkOutput("post-flush count",     32'(count),     32'd0);
    checkOutput("post-flush out_valid", 32'(out_valid), 32'd0);
    applyStimulus(1'b1, 32'h0800_0c00, 32'h3400, 1'b0, 1'b0);
    checkOutput("redirect head pc",    out_pc,         32'h3400);
    checkOutput("redirect head instr", out_instr,      32'h0800_0c00);
    checkOutput("redirect count",      32'(count),     32'd1);

    // Asynchronous reset mid-cycle at count 2.
    applyStimulus(1'b1, 32'h0800_0c01, 32'h3404, 1'b0, 1'b0);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checkOutput("pre-reset count", 32'(count), 32'd2);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async reset count",     32'(count),     32'd0);
    checkOutput("async reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("async reset out_pc",    out_pc,         32'h0000_3000);
    model_instr.delete();
    model_pc.delete();
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;

`ifdef FETCH_QUEUE_BYPASS_EN
    // Zero-latency pass-through while empty.
    in_valid  = 1'b1;
    in_instr  = 32'h2408_0001;
    in_pc     = 32'h3000;
    out_ready = 1'b1;
    flush     = 1'b0;
    #1;
    checkOutput("bypass out_valid", 32'(out_valid), 32'd1);
    checkOutput("bypass out_pc",    out_pc,         32'h3000);
    applyStimulus(1'b1, 32'h2408_0001, 32'h3000, 1'b1, 1'b0);
    in_valid = 1'b0;
    #1;
    checkOutput("bypass count", 32'(count), 32'd0);
    @(posedge clk);
    #1;
`endif

    // Random traffic against the model.
    pc_next = 32'h3000;
    for (int i = 0; i < 400; i++) begin
      logic iv, ordy, fl;
      iv   = ($urandom_range(0, 9) < 7);
      ordy = ($urandom_range(0, 9) < 5);
      fl   = ($urandom_range(0, 19) == 0);
      applyStimulus(iv, $urandom, pc_next, ordy, fl);
      if (iv) pc_next = pc_next + 32'd4;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    @(negedge clk);
    compareModel();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
